fetch_redirect_ctrl: RTL

- Sequencing controller for the fetch stage's PC update.
- Arbitrates redirect requests from MEM (taken branch) and ID (jump), applying priority by instruction age.
- Buffers a redirect that arrives while the pipeline is stalled and releases it when the stall clears.
- Generates per-stage flush pulses, and feeds the fetch stage's jump/branch/stall inputs through its redirect outputs.

---
 rtl/fetch_redirect_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: sequencing controller for the fetch stage PC update.
// Arbitrates MEM branch and ID jump redirects by age (branch wins), buffers
// a redirect that arrives during a pipeline stall and releases it when the
// stall clears, and generates per-stage flush pulses.
//
// Optional feature macro: REDIRECT_STATS_EN
//   defined   -> 16-bit wrapping branch/jump redirect counters
//   undefined -> branch_count/jump_count tied to 0, no counter flops
//
// Handshake: there is no backpressure. redirect_valid is a single-cycle
// qualifier; when it is high the PC loads redirect_addr at the next rising
// edge. redirect_addr and redirect_is_branch are meaningful only while
// redirect_valid is high and are driven to 0 otherwise.
//
// FSM state is observable through redirect_pending (high exactly in HOLD).
module fetch_redirect_ctrl #(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_taken,
  input  logic [PC_W-1:0]        branch_addr,
  input  logic                   is_jump,
  input  logic [PC_W-1:0]        jump_addr,
  input  logic                   stall_pipeline,
  output logic                   redirect_valid,
  output logic [PC_W-1:0]        redirect_addr,
  output logic                   redirect_is_branch,
  output logic                   pc_hold,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   flush_ex_mem,
  output logic                   redirect_pending,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [15:0]            branch_count,
  output logic [15:0]            jump_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [PC_W-1:0]        pend_addr_q, pend_addr_d;
  logic                   pend_br_q, pend_br_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // State and pending-entry registers; reset drops any buffered redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_br_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_br_q    <= pend_br_d;
    end
  end

  // Next-state, pending capture and combinational redirect/flush outputs.
  always_comb begin
    state_d            = state_q;
    pend_valid_d       = pend_valid_q;
    pend_addr_d        = pend_addr_q;
    pend_br_d          = pend_br_q;
    redirect_valid     = 1'b0;
    redirect_addr      = '0;
    redirect_is_branch = 1'b0;
    pc_hold            = 1'b0;
    flush_if_id        = 1'b0;
    flush_id_ex        = 1'b0;
    flush_ex_mem       = 1'b0;

    // Outputs stay at 0 while reset is held, even with live requests.
    if (rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stall_pipeline) begin
            if (branch_taken) begin
              redirect_valid     = 1'b1;
              redirect_addr      = branch_addr;
              redirect_is_branch = 1'b1;
              flush_if_id        = 1'b1;
              flush_id_ex        = 1'b1;
              flush_ex_mem       = 1'b1;
            end else if (is_jump) begin
              redirect_valid = 1'b1;
              redirect_addr  = jump_addr;
              flush_if_id    = 1'b1;
            end
          end else begin
            pc_hold = 1'b1;
            if (branch_taken) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = branch_addr;
              pend_br_d    = 1'b1;
              state_d      = ST_HOLD;
            end else if (is_jump) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = jump_addr;
              pend_br_d    = 1'b0;
              state_d      = ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (stall_pipeline) begin
            pc_hold = 1'b1;
            // A jump here is the held ID instruction again (or younger): drop it.
            if (branch_taken) begin
              pend_addr_d = branch_addr;
              pend_br_d   = 1'b1;
            end
          end else begin
            redirect_valid = 1'b1;
            flush_if_id    = 1'b1;
            if (branch_taken) begin
              redirect_addr      = branch_addr;
              redirect_is_branch = 1'b1;
              flush_id_ex        = 1'b1;
              flush_ex_mem       = 1'b1;
            end else begin
              redirect_addr      = pend_addr_q;
              redirect_is_branch = pend_br_q;
              flush_id_ex        = pend_br_q;
              flush_ex_mem       = pend_br_q;
            end
            pend_valid_d = 1'b0;
            pend_addr_d  = '0;
            pend_br_d    = 1'b0;
            state_d      = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign redirect_pending = pend_valid_q;

  // Saturating count of consecutive stalled cycles.
  always_comb begin
    stall_cnt_d = '0;
    if (stall_pipeline) begin
      if (stall_cnt_q == {STALL_CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q;
      end else begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

`ifdef REDIRECT_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] jp_cnt_q, jp_cnt_d;

  // Per-source redirect counters, wrapping at 16 bits.
  always_comb begin
    br_cnt_d = br_cnt_q;
    jp_cnt_d = jp_cnt_q;
    if (redirect_valid) begin
      if (redirect_is_branch) begin
        br_cnt_d = br_cnt_q + 16'd1;
      end else begin
        jp_cnt_d = jp_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q <= '0;
      jp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      jp_cnt_q <= jp_cnt_d;
    end
  end

  assign branch_count = br_cnt_q;
  assign jump_count   = jp_cnt_q;
`else
  assign branch_count = 16'd0;
  assign jump_count   = 16'd0;
`endif

endmodule
